// File: rtl/stack_seq_pkg.sv
// Shared opcode, error and state encodings for the stack operation sequencer.
// Pure definitions: no logic, no latency, no flow control.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_XOR  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_UNDER    = 2'b01,
    ERR_OVER     = 2'b10,
    ERR_MISMATCH = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP_B = 3'd1,
    S_CAP_B = 3'd2,
    S_POP_A = 3'd3,
    S_CAP_A = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/stack_alu.sv
// Binary stack ALU: a OP b with a = word below top, b = old top; SUB is a-b, modulo 2^WIDTH.
// Purely combinational, no flow control.
module stack_alu
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stack_seq.sv
// Sole master of a hardware stack: runs one PUSH/POP/NOP/ALU op at a time with a one-cycle done pulse.
// Latency accept->done: NOP/reject 1, PUSH 2, POP 3, ALU 6; op_ready only in IDLE, op_valid ignored otherwise.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [2:0]                 op_code,
  input  logic [WIDTH-1:0]           op_imm,
  output logic                       done,
  output logic [1:0]                 err,
  output logic [WIDTH-1:0]           res_data,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [WIDTH-1:0]           stk_din,
  input  logic [WIDTH-1:0]           stk_dout,
  input  logic                       stk_full,
  input  logic                       stk_empty
);

  localparam int DW = $clog2(DEPTH + 1);

  state_e           state, state_n;
  op_e              op_q, op_n;
  logic [DW-1:0]    depth_q, depth_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n, result_q, result_n, res_q, res_n;
  err_e             err_q, err_n;
  logic [WIDTH-1:0] alu_res, wr_dat;

  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res)
  );

  assign wr_dat = (op_q == OP_PUSH) ? result_q : alu_res;

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    depth_n  = depth_q;
    a_n      = a_q;
    b_n      = b_q;
    result_n = result_q;
    err_n    = err_q;
    res_n    = res_q;
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          op_n     = op_e'(op_code);
          err_n    = ERR_OK;
          res_n    = '0;
          result_n = op_imm;
          case (op_e'(op_code))
            OP_NOP:  state_n = S_DONE;
            OP_PUSH: begin
              if (depth_q == DW'(DEPTH)) begin
                err_n   = ERR_OVER;
                state_n = S_DONE;
              end else begin
                res_n   = op_imm;
                state_n = S_WRITE;
              end
            end
            OP_POP: begin
              if (depth_q == '0) begin
                err_n   = ERR_UNDER;
                state_n = S_DONE;
              end else begin
                state_n = S_POP_B;
              end
            end
            default: begin
              if (depth_q < DW'(2)) begin
                err_n   = ERR_UNDER;
                state_n = S_DONE;
              end else begin
                state_n = S_POP_B;
              end
            end
          endcase
        end
      end
      // An empty stack here means our depth count disagrees with the stack.
      S_POP_B, S_POP_A: begin
        if (stk_empty) begin
          err_n   = ERR_MISMATCH;
          state_n = S_DONE;
        end else begin
          depth_n = depth_q - DW'(1);
          state_n = (state == S_POP_B) ? S_CAP_B : S_CAP_A;
        end
      end
      S_CAP_B: begin
        b_n = stk_dout;
        if (op_q == OP_POP) begin
          res_n   = stk_dout;
          state_n = S_DONE;
        end else begin
          state_n = S_POP_A;
        end
      end
      S_CAP_A: begin
        a_n     = stk_dout;
        state_n = S_WRITE;
      end
      S_WRITE: begin
        res_n    = wr_dat;
        result_n = wr_dat;
        if (stk_full) err_n = ERR_MISMATCH;
        else          depth_n = depth_q + DW'(1);
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      depth_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= ERR_OK;
      res_q    <= '0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      depth_q  <= depth_n;
      a_q      <= a_n;
      b_q      <= b_n;
      result_q <= result_n;
      err_q    <= err_n;
      res_q    <= res_n;
    end
  end

  // Strobes are suppressed when the stack flags contradict the tracked depth.
  assign op_ready = (state == S_IDLE);
  assign done     = (state == S_DONE);
  assign err      = err_q;
  assign res_data = res_q;
  assign depth    = depth_q;
  assign stk_pop  = ((state == S_POP_B) || (state == S_POP_A)) && !stk_empty;
  assign stk_push = (state == S_WRITE) && !stk_full;
  assign stk_din  = (state == S_WRITE) ? wr_dat : '0;

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: behavioural stack model, table of directed ops, plus mismatch and mid-op reset sequences.
module tb_stack_seq;
  import stack_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 10;

  logic             clk, reset;
  logic             op_valid, op_ready, done;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_imm, res_data, stk_din, stk_dout;
  logic [1:0]       err;
  logic [3:0]       depth;
  logic             stk_push, stk_pop, stk_full, stk_empty;

  int n_tests = 0;
  int n_fail  = 0;

  stack_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_imm(op_imm), .done(done), .err(err),
    .res_data(res_data), .depth(depth), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_din(stk_din), .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Stack model; fake_* flags let the bench inject a flag/depth disagreement.
  logic [WIDTH-1:0] mem [DEPTH];
  int               sp;
  logic             fake_full, fake_empty;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp       <= 0;
      stk_dout <= '0;
    end else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp       <= sp - 1;
    end
  end

  assign stk_full  = (sp == DEPTH) || fake_full;
  assign stk_empty = (sp == 0) || fake_empty;

  always @(negedge clk) begin
    if (stk_push && stk_pop) begin
      n_fail++;
      $display("FAIL strobe_overlap: push=%0d pop=%0d, required never both", stk_push, stk_pop);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] code, input logic [WIDTH-1:0] imm,
                        output int lat, output int e, output int r,
                        output int pushes, output int pops, output int done_after);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    op_imm   = imm;
    for (int k = 0; k < 20 && !op_ready; k++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    lat = 99; e = -1; r = -1; pushes = 0; pops = 0;
    for (int c = 1; c <= 20; c++) begin
      pushes += int'(stk_push);
      pops   += int'(stk_pop);
      if (done) begin
        lat = c; e = int'(err); r = int'(res_data);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    done_after = int'(done);
  endtask

  typedef struct {
    logic [2:0]       code;
    logic [WIDTH-1:0] imm;
    int lat, err, res, depth, pushes, pops;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [2:0] code, input logic [WIDTH-1:0] imm,
                              input int lat, input int e, input int res, input int d,
                              input int pushes, input int pops);
    vec_t v;
    v.code = code; v.imm = imm; v.lat = lat; v.err = e; v.res = res;
    v.depth = d; v.pushes = pushes; v.pops = pops;
    vt.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int lat, e, r, pu, po, da;
    run_op(v.code, v.imm, lat, e, r, pu, po, da);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_err"}, e, v.err);
    chk({tag, "_res"}, r, v.res);
    chk({tag, "_depth"}, int'(depth), v.depth);
    chk({tag, "_model_sp"}, sp, v.depth);
    chk({tag, "_pushes"}, pu, v.pushes);
    chk({tag, "_pops"}, po, v.pops);
    chk({tag, "_done_1cyc"}, da, 0);
  endtask

  initial begin
    int   ndone;
    vec_t v;
    reset = 1'b0; op_valid = 1'b0; op_code = 3'b000; op_imm = '0;
    fake_full = 1'b0; fake_empty = 1'b0;

    #12;
    chk("rst_op_ready", int'(op_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_res", int'(res_data), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_push", int'(stk_push), 0);
    chk("rst_pop", int'(stk_pop), 0);
    chk("rst_din", int'(stk_din), 0);
    @(negedge clk);
    reset = 1'b1;

    //  code  imm       lat err res      depth push pop
    add(3'b001, 4'b1010, 2, 0, 4'b1010, 1, 1, 0);
    add(3'b001, 4'b1111, 2, 0, 4'b1111, 2, 1, 0);
    add(3'b100, 4'b0000, 6, 0, 4'b1011, 1, 1, 2);   // 1010-1111
    add(3'b010, 4'b0000, 3, 0, 4'b1011, 0, 0, 1);
    add(3'b010, 4'b0000, 1, 1, 0,       0, 0, 0);   // underflow
    for (int i = 0; i < 10; i++) add(3'b001, 4'b0001, 2, 0, 1, i + 1, 1, 0);
    add(3'b001, 4'b0111, 1, 2, 0,       10, 0, 0);  // overflow
    for (int i = 0; i < 9; i++) add(3'b010, 4'b0000, 3, 0, 1, 9 - i, 0, 1);
    add(3'b011, 4'b0000, 1, 1, 0,       1, 0, 0);   // ALU with one word
    add(3'b001, 4'b1000, 2, 0, 4'b1000, 2, 1, 0);
    add(3'b001, 4'b1001, 2, 0, 4'b1001, 3, 1, 0);
    add(3'b011, 4'b0000, 6, 0, 4'b0001, 2, 1, 2);   // 1000+1001 wraps
    add(3'b000, 4'b1111, 1, 0, 0,       2, 0, 0);
    add(3'b001, 4'b0110, 2, 0, 4'b0110, 3, 1, 0);
    add(3'b111, 4'b0000, 6, 0, 4'b0111, 2, 1, 2);   // 0001^0110
    add(3'b001, 4'b1100, 2, 0, 4'b1100, 3, 1, 0);
    add(3'b101, 4'b0000, 6, 0, 4'b0100, 2, 1, 2);   // 0111&1100
    add(3'b001, 4'b0011, 2, 0, 4'b0011, 3, 1, 0);
    add(3'b110, 4'b0000, 6, 0, 4'b0111, 2, 1, 2);   // 0100|0011
    add(3'b100, 4'b0000, 6, 0, 4'b1010, 1, 1, 2);   // 0001-0111

    for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("vec%0d", i));

    // Stack reports empty while depth=1: no pop strobe, mismatch, depth kept.
    fake_empty = 1'b1;
    v = '{code: 3'b010, imm: 4'b0000, lat: 2, err: 3, res: 0, depth: 1, pushes: 0, pops: 0};
    apply(v, "mm_empty");
    fake_empty = 1'b0;

    fake_full = 1'b1;
    v = '{code: 3'b001, imm: 4'b0101, lat: 2, err: 3, res: 5, depth: 1, pushes: 0, pops: 0};
    apply(v, "mm_full");
    fake_full = 1'b0;

    // Reset while an XOR sits in CAP_A.
    v = '{code: 3'b001, imm: 4'b0010, lat: 2, err: 0, res: 2, depth: 2, pushes: 1, pops: 0};
    apply(v, "pre_xor0");
    v = '{code: 3'b001, imm: 4'b0100, lat: 2, err: 0, res: 4, depth: 3, pushes: 1, pops: 0};
    apply(v, "pre_xor1");
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'b111;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midop_busy", int'(op_ready), 0);
    chk("midop_depth", int'(depth), 1);
    reset = 1'b0;
    #1;
    chk("arst_op_ready", int'(op_ready), 1);
    chk("arst_done", int'(done), 0);
    chk("arst_depth", int'(depth), 0);
    chk("arst_push", int'(stk_push), 0);
    chk("arst_pop", int'(stk_pop), 0);
    chk("arst_din", int'(stk_din), 0);
    chk("arst_res", int'(res_data), 0);
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      ndone += int'(done);
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("arst_no_done", ndone, 0);
    chk("arst_depth_after", int'(depth), 0);
    chk("arst_stk_empty", int'(stk_empty), 1);

    v = '{code: 3'b001, imm: 4'b0011, lat: 2, err: 0, res: 3, depth: 1, pushes: 1, pops: 0};
    apply(v, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Operation sequencer that sits directly upstream of the hardware stack and is its only master. It drives the stack's push, pop and data_in and consumes its data_out, full and empty.
- Accepts one stack-machine operation at a time over a valid/ready handshake: immediate push, pop, NOP, or a binary ALU op (pop b, pop a, push a OP b).
- Keeps its own depth counter so that underflow and overflow are rejected before any stack strobe is issued.

Parameters:
WIDTH, 4, data word width; must equal the stack's width.
DEPTH, 10, stack capacity in words; must equal the stack's depth.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
op_valid  in  1  operation request.
op_ready  out  1  high only in IDLE; an op is accepted on an edge where op_valid && op_ready.
op_code  in  3  000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 AND, 110 OR, 111 XOR.
op_imm  in  WIDTH  immediate for PUSH; sampled at accept.
done  out  1  one-cycle pulse when the op completes (also on error).
err  out  2  valid with done: 00 ok, 01 underflow, 10 overflow, 11 stack mismatch.
res_data  out  WIDTH  valid with done: popped value (POP), result (ALU), op_imm (PUSH), 0 otherwise.
depth  out  $clog2(DEPTH+1)  tracked stack occupancy.
stk_push  out  1  to stack push.
stk_pop  out  1  to stack pop.
stk_din  out  WIDTH  to stack data_in.
stk_dout  in  WIDTH  from stack data_out.
stk_full  in  1  from stack full.
stk_empty  in  1  from stack empty.

Behaviour:
- Stack contract:
  - The stack writes stk_din on an edge where stk_push=1.
  - On an edge where stk_pop=1, the stack registers the top word to stk_dout, so that word is valid the cycle after the pop strobe.
  - stk_push and stk_pop are never asserted together.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; depth=0; internal a/b/result registers clear.
  - done=0, err=00, res_data=0, stk_push=0, stk_pop=0, stk_din=0.
  - op_ready is decoded from IDLE, so it is 1 during reset.
  - Reset mid-operation abandons the op with no done pulse. The stack shares the same reset, so depth=0 stays consistent with it.
- States: IDLE, POP_B, CAP_B, POP_A, CAP_A, WRITE, DONE. Outputs are registered or decoded from state only; there is no combinational path from op_valid to any output.
- IDLE, at accept, with the opcode and op_imm latched:
  - NOP goes to DONE.
  - PUSH: if depth==DEPTH, err=10 and go to DONE; else go to WRITE with the result register set to op_imm.
  - POP: if depth==0, err=01 and go to DONE; else go to POP_B.
  - ALU: if depth<2, err=01 and go to DONE; else go to POP_B.
- POP_B: stk_pop=1; depth-1.
  - If stk_empty=1 on entry, no strobe is issued, err=11 and go to DONE.
  - Otherwise go to CAP_B.
- CAP_B: b <= stk_dout. A POP op goes to DONE with res_data=b; an ALU op goes to POP_A.
- POP_A: same as POP_B, including the mismatch check. Then go to CAP_A.
- CAP_A: a <= stk_dout; go to WRITE.
- WRITE: stk_push=1, stk_din=result; depth+1.
  - If stk_full=1, no strobe is issued and err=11.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, with err and res_data held stable; then go to IDLE.
- ALU arithmetic:
  - b is the old top of stack; a is the word below it.
  - SUB computes a-b. ADD and SUB are modulo 2^WIDTH with no carry out. AND, OR and XOR are bitwise.
- Latency from accept edge to done cycle:
  - NOP or any rejected op: 1 cycle.
  - PUSH: 2 cycles.
  - POP: 3 cycles.
  - ALU: 6 cycles.
- Net depth change: PUSH +1, POP -1, ALU -1, errors 0 except a mid-op mismatch (depth then follows the strobes actually issued).
- op_valid is ignored outside IDLE; the next op may be accepted the cycle after DONE.

Decomposition:
- Shared definitions file stack_defs.vh: opcode constants, err codes, state encodings.
- One combinational sub-module, stack_alu: inputs a, b, op; output result; WIDTH parameter.

Test Plan:
- Reset release, then PUSH 1010, then PUSH 1111 -> two done pulses, err=00; stk_push high for one cycle each; depth=2; the stack holds 1111 on top.
- From that state, SUB -> done 6 cycles after accept; res_data=1011 (1010-1111 mod 16); depth=1; the stack holds 1011.
- POP on depth=1 -> res_data=1011, err=00, depth=0, stk_empty=1; a following POP -> done next cycle, err=01, no stk_pop strobe.
- PUSH 0001 ten times, then an eleventh PUSH -> err=10, depth=10, stk_push never asserted for the eleventh.
- ADD with depth=1 -> err=01, no stack strobes, depth unchanged; PUSH 1000 then PUSH 1001 then ADD -> res_data=0001 (wrap).
- Drive reset=0 during CAP_A of an XOR -> outputs clear immediately, op_ready=1, no done pulse; after release, depth=0 and stk_empty=1.
